// File: rtl/word_store_serializer.sv
// -----------------------------------------------------------------------------
// word_store_serializer
//
// Purpose:
//   Store-side partner of the byte-wise fetch path. It takes one word of
//   8*BYTES bits and a base byte address from the multicycle controller. It
//   then writes the word to an 8-bit memory as BYTES sequential byte writes.
//   Byte order is little-endian: byte k of the word goes to address
//   (base + k) mod 2^ADDR_W.
//
// Optional feature (compile-time macro STORE_READBACK_EN):
//   After every acknowledged byte write, the block reads the same address back
//   and compares the result with the written byte. Any mismatch sets a sticky
//   error flag, which is reported on o_err together with o_done. With the macro
//   undefined there is no VERIFY state, o_mem_re and o_err are constant 0, and
//   i_mem_rdata is ignored.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_rst        synchronous active-high reset; forces every output to 0
//   i_req_valid  store request from the controller
//   o_req_ready  request can be accepted (IDLE only)
//   i_req_addr   base byte address of the word
//   i_req_data   word to store
//   o_mem_addr   memory byte address (0 outside an access)
//   o_mem_wdata  memory write data   (0 outside an access)
//   o_mem_we     memory write strobe
//   o_mem_re     memory read strobe (readback only)
//   i_mem_rdata  memory read data (readback only)
//   i_mem_ack    memory completes the current access this cycle
//   o_busy       a request is in progress (any state except IDLE)
//   o_done       one-cycle pulse when the store has finished
//   o_err        valid with o_done: a readback mismatch occurred
// -----------------------------------------------------------------------------
module word_store_serializer #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned BYTES  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [ADDR_W-1:0]    i_req_addr,
  input  logic [8*BYTES-1:0]   i_req_data,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [7:0]           o_mem_wdata,
  output logic                 o_mem_we,
  output logic                 o_mem_re,
  input  logic [7:0]           i_mem_rdata,
  input  logic                 i_mem_ack,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int unsigned DataW = 8 * BYTES;
  localparam int unsigned IdxW  = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef STORE_READBACK_EN
  typedef enum logic [1:0] {StIdle, StWrite, StVerify, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;
`endif

  // Transaction state.
  state_e              r_state;
  logic [IdxW-1:0]     r_idx;
  logic [ADDR_W-1:0]   r_addr;
  logic [DataW-1:0]    r_data;

  // Registered outputs. They are gated by i_rst below so that every output
  // reads 0 in the same cycle that reset is asserted, not only after the edge.
  logic                r_req_ready;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic                r_mem_we;
  logic                r_mem_re;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  // Next-byte helpers used when the current byte completes.
  logic                w_last;
  logic [IdxW-1:0]     w_next_idx;
  logic [ADDR_W-1:0]   w_next_addr;
  logic [7:0]          w_next_byte;
  logic                w_err_next;

  assign w_last      = (r_idx == IdxW'(BYTES - 1));
  assign w_next_idx  = r_idx + 1'b1;
  // The adder is ADDR_W bits wide, so base+index wraps modulo 2^ADDR_W.
  assign w_next_addr = r_addr + ADDR_W'(w_next_idx);
  assign w_next_byte = 8'(r_data >> {w_next_idx, 3'b000});

`ifdef STORE_READBACK_EN
  logic r_err_flag;
  logic w_mismatch;

  // r_mem_wdata still holds the byte that was just written during VERIFY.
  assign w_mismatch = (i_mem_rdata != r_mem_wdata);
  assign w_err_next = r_err_flag | w_mismatch;
`else
  logic w_unused_rdata;

  assign w_unused_rdata = ^i_mem_rdata;
  assign w_err_next     = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      // Reset leaves the block in IDLE. The output gating hides this until
      // i_rst drops, so ready appears on the first cycle after release.
      r_req_ready <= 1'b1;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef STORE_READBACK_EN
      r_err_flag  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_req_valid && r_req_ready) begin
            r_state     <= StWrite;
            r_idx       <= '0;
            r_addr      <= i_req_addr;
            r_data      <= i_req_data;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= i_req_addr;
            r_mem_wdata <= i_req_data[7:0];
`ifdef STORE_READBACK_EN
            r_err_flag  <= 1'b0;
`endif
          end
        end

        StWrite: begin
          if (i_mem_ack) begin
`ifdef STORE_READBACK_EN
            // Read back the same address; the address and data are held.
            r_state  <= StVerify;
            r_mem_we <= 1'b0;
            r_mem_re <= 1'b1;
`else
            if (w_last) begin
              r_state     <= StDone;
              r_mem_we    <= 1'b0;
              r_mem_re    <= 1'b0;
              r_mem_addr  <= '0;
              r_mem_wdata <= '0;
              r_done      <= 1'b1;
              r_err       <= w_err_next;
            end else begin
              r_idx       <= w_next_idx;
              r_mem_addr  <= w_next_addr;
              r_mem_wdata <= w_next_byte;
            end
`endif
          end
        end

`ifdef STORE_READBACK_EN
        StVerify: begin
          if (i_mem_ack) begin
            r_err_flag <= w_err_next;
            r_mem_re   <= 1'b0;
            if (w_last) begin
              r_state     <= StDone;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= '0;
              r_mem_wdata <= '0;
              r_done      <= 1'b1;
              r_err       <= w_err_next;
            end else begin
              r_state     <= StWrite;
              r_idx       <= w_next_idx;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_next_addr;
              r_mem_wdata <= w_next_byte;
            end
          end
        end
`endif

        StDone: begin
          r_state     <= StIdle;
          r_done      <= 1'b0;
          r_err       <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end

        default: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
          r_mem_we    <= 1'b0;
          r_mem_re    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_err       <= 1'b0;
        end
      endcase
    end
  end

  // A mid-transfer reset drops the strobes in the reset cycle itself.
  assign o_req_ready = i_rst ? 1'b0 : r_req_ready;
  assign o_mem_addr  = i_rst ? '0   : r_mem_addr;
  assign o_mem_wdata = i_rst ? '0   : r_mem_wdata;
  assign o_mem_we    = i_rst ? 1'b0 : r_mem_we;
  assign o_busy      = i_rst ? 1'b0 : r_busy;
  assign o_done      = i_rst ? 1'b0 : r_done;

`ifdef STORE_READBACK_EN
  assign o_mem_re    = i_rst ? 1'b0 : r_mem_re;
  assign o_err       = i_rst ? 1'b0 : r_err;
`else
  logic w_unused_regs;

  assign w_unused_regs = r_mem_re | r_err;
  assign o_mem_re      = 1'b0;
  assign o_err         = 1'b0;
`endif

endmodule

// File: doc/word_store_serializer.md
Name: word_store_serializer

Overview:
- Store-side counterpart of the byte-wise instruction/operand fetch path.
- Accepts one 16-bit word plus a 13-bit base address from the multicycle controller and writes it to the 8-bit memory as BYTES sequential byte writes.
- Byte order is little-endian: the low byte goes to the base address, the high byte to base+1.
- Sits between the controller/datapath and the memory port.

Parameters:
ADDR_W, 13, memory address width
BYTES, 2, bytes per stored word (word width = 8*BYTES)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
req_valid  in  1  store request
req_ready  out  1  block can accept a request (IDLE only)
req_addr  in  ADDR_W  base byte address
req_data  in  8*BYTES  word to store
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  8  memory write data
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe (readback feature only)
mem_rdata  in  8  memory read data
mem_ack  in  1  memory completes current access this cycle
busy  out  1  request in progress (any state except IDLE)
done  out  1  one-cycle pulse: store finished
err  out  1  valid with done: readback mismatch

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - On a clk edge with rst=1: state=IDLE, byte index=0, latched addr/data=0, err flag=0.
  - While rst=1, all outputs are forced 0 (req_ready, mem_we, mem_re, busy, done, err, mem_addr, mem_wdata).
  - req_ready rises the first cycle after rst deasserts.
- States: IDLE, WRITE, [VERIFY], DONE.
- IDLE:
  - req_ready=1; mem_we=mem_re=0.
  - On req_valid & req_ready: latch req_addr and req_data, set index=0, clear err flag, go to WRITE.
- WRITE:
  - mem_we=1.
  - mem_addr = (base + index) mod 2^ADDR_W, so 0x1FFF+1 wraps to 0x0000.
  - mem_wdata = data[8*index+7 : 8*index].
  - Outputs are held stable until mem_ack=1.
  - On ack:
    - With the feature, go to VERIFY.
    - Otherwise, if index==BYTES-1 go to DONE; else index+1 and stay in WRITE.
- DONE:
  - done=1 and err=err flag for exactly one cycle; req_ready=0.
  - Then return to IDLE.
- Latency:
  - With mem_ack tied 1 and no feature, done asserts BYTES+1 cycles after the accept edge (3 for the default).
  - Each extra cycle of mem_ack low adds one cycle.
- mem_ack is ignored in IDLE and DONE.
- req_valid is ignored whenever req_ready=0; the request stays with the requester (no queueing).
- rst asserted mid-operation: the transfer aborts with no done pulse; mem_we/mem_re are 0 from that cycle onward.
- mem_addr and mem_wdata are 0 in IDLE and DONE.

Optional Feature:
- Macro: STORE_READBACK_EN.
- Defined:
  - After each WRITE ack, enter VERIFY: mem_re=1, mem_we=0, same mem_addr, held until mem_ack.
  - On ack, compare mem_rdata with the written byte; a mismatch sets the sticky err flag.
  - Then advance the index or go to DONE, using the same rule as WRITE.
  - err reports the flag with done. The flag clears on the next accept.
  - Latency with ack tied 1 is 2*BYTES+1.
- Not defined:
  - No VERIFY state.
  - mem_re and err are constant 0, and mem_rdata is unused.

Test Plan:
- Basic store: rst pulse, ack tied 1; req addr=0x0100, data=0xBEEF.
  - Expect write 0xEF@0x0100, then 0xBE@0x0101.
  - done on cycle 3 after accept; err=0; req_ready back to 1 the next cycle.
- Wait states: ack low for 2 cycles on each byte.
  - mem_we, mem_addr and mem_wdata hold steady; done at cycle 7.
- Address wrap: addr=0x1FFF, data=0x1234.
  - Expect 0x34@0x1FFF, then 0x12@0x0000.
- Back-to-back and ignored requests:
  - req_valid held high during busy: no second accept until IDLE.
  - The second request (0x0200/0xA55A) is accepted the cycle after done.
- Reset mid-store: assert rst after the first byte's ack.
  - Expect no done; mem_we=0 in the rst cycle and after; req_ready=1 after release.
- (STORE_READBACK_EN) Readback: memory returns 0xEF then 0x00 for data 0xBEEF.
  - Expect mem_re after each write; done with err=1.
  - The next clean store gives err=0.
